// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between the CPU load/store path and data_mem_ctrl.
//
// Signals:
//   req_valid   CPU -> ctrl  request present
//   req_ready   ctrl -> CPU  controller can accept a request
//   mem_read    CPU -> ctrl  load request
//   mem_write   CPU -> ctrl  store request (wins over mem_read)
//   size        CPU -> ctrl  00 byte, 01 half, 10 word, 11 illegal
//   sign_ext    CPU -> ctrl  sign-extend sub-word loads when 1
//   address     CPU -> ctrl  byte address (ALU result)
//   write_data  CPU -> ctrl  store operand, right-aligned
//   resp_valid  ctrl -> CPU  one-cycle response pulse
//   read_data   ctrl -> CPU  load result, held until the next response
//   misaligned  ctrl -> CPU  error flag, valid with resp_valid
//   busy        ctrl -> CPU  stall while an access is in flight
//
// Modports: master = CPU side, slave = controller side.
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic              resp_valid;
    logic [31:0]       read_data;
    logic              misaligned;
    logic              busy;

    modport master (
        output req_valid, mem_read, mem_write, size, sign_ext, address, write_data,
        input  req_ready, resp_valid, read_data, misaligned, busy
    );

    modport slave (
        input  req_valid, mem_read, mem_write, size, sign_ext, address, write_data,
        output req_ready, resp_valid, read_data, misaligned, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Load/store stage behind the CPU ALU. Accepts one byte/half/word access at a
// time, waits WAIT_CYCLES to model slow memory, then commits to an internal
// word-wide little-endian RAM and returns a one-cycle response.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (asserted when 0)
//   bus    data_mem_ctrl_if slave modport (request/response handshake)
//
// Parameters:
//   ADDR_W       byte-address width
//   WAIT_CYCLES  wait states between accept and commit (0..15)
//   INIT_ZERO    1 = RAM starts zeroed; reset never clears the RAM
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter bit INIT_ZERO   = 1'b1
) (
    input logic            clk,
    input logic            reset,
    data_mem_ctrl_if.slave bus
);

    localparam int         DEPTH     = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_sign;
    logic [31:0]       lat_wdata;
    logic              lat_read;
    logic              lat_write;

    logic              resp_valid_q;
    logic [31:0]       read_data_q;
    logic              misaligned_q;

    // RAM content is set up once at elaboration and never touched by reset.
    logic [31:0]       mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       mem_word;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lanes;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_value;
    logic              accept;
    logic              req_err;
    logic              lat_err;

    // Illegal size, or an address not aligned to the access size.
    function automatic logic access_err(input logic [1:0] sz, input logic [1:0] low);
        case (sz)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = low[0];
            2'b10:   access_err = (low != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    assign accept   = bus.req_valid && (state == S_IDLE);
    assign req_err  = access_err(bus.size, bus.address[1:0]);
    assign lat_err  = access_err(lat_size, lat_addr[1:0]);
    assign word_idx = lat_addr[ADDR_W-1:2];
    assign mem_word = mem[word_idx];

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.read_data  = read_data_q;
    assign bus.misaligned = misaligned_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Errors skip the wait states entirely so the CPU learns about them fast.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err || (WAIT_CYCLES == 0)) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Request fields are captured at accept so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_sign  <= 1'b0;
            lat_wdata <= 32'h0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
        end else if (accept) begin
            wait_cnt  <= WAIT_LOAD;
            lat_addr  <= bus.address;
            lat_size  <= bus.size;
            lat_sign  <= bus.sign_ext;
            lat_wdata <= bus.write_data;
            lat_read  <= bus.mem_read;
            lat_write <= bus.mem_write;
        end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Store data is replicated across lanes so the byte enables pick the slot.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = lat_wdata;
        case (lat_size)
            2'b00: begin
                byte_en     = 4'b0001 << lat_addr[1:0];
                wdata_lanes = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = lat_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{lat_wdata[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    always_comb begin
        sel_byte   = mem_word[{lat_addr[1:0], 3'b000} +: 8];
        sel_half   = lat_addr[1] ? mem_word[31:16] : mem_word[15:0];
        load_value = 32'h0;
        case (lat_size)
            2'b00:   load_value = {{24{lat_sign & sel_byte[7]}}, sel_byte};
            2'b01:   load_value = {{16{lat_sign & sel_half[15]}}, sel_half};
            2'b10:   load_value = mem_word;
            default: load_value = 32'h0;
        endcase
    end

    // The RESP edge is the only commit point; an async reset before it drops
    // the state to IDLE, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && lat_write && !lat_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // Stores and NOPs leave read_data holding the previous load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            read_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            resp_valid_q <= (state == S_RESP);
            misaligned_q <= (state == S_RESP) && lat_err;
            if (state == S_RESP) begin
                if (lat_err) begin
                    read_data_q <= 32'h0;
                end else if (!lat_write && lat_read) begin
                    read_data_q <= load_value;
                end
            end
        end
    end

endmodule
